// File: rtl/register_file_mc.sv
`default_nettype none
// register_file_mc: decodes strobed GPO command words into Tx/Rx, phase, log-memory and
// software-reset controls, and returns snapshotted BER counters and status on GPI.
// Revision: 1.0
module register_file_mc #(
   parameter int NB_ADDR_MEM = 15,
   parameter int N_CH        = 4,
   parameter int NB_PHASE    = 2,
   parameter int NB_CNT      = 64,
   parameter int MEM_RD_LAT  = 1,
   parameter int RST_LEN     = 4
) (
   input  logic                   clk,
   input  logic                   i_rst,
   input  logic [31:0]            i_gpo,
   input  logic [31:0]            i_data_log_from_mem,
   input  logic                   i_mem_full,
   input  logic [N_CH*NB_CNT-1:0] i_ber_samp,
   input  logic [N_CH*NB_CNT-1:0] i_ber_error,
   output logic [31:0]            o_gpi,
   output logic                   o_rst,
   output logic                   o_enbTx,
   output logic                   o_enbRx,
   output logic [NB_PHASE-1:0]    o_phase_sel,
   output logic                   o_run_log,
   output logic                   o_read_log,
   output logic [NB_ADDR_MEM-1:0] o_addr_log_to_mem,
   output logic                   o_cmd_done,
   output logic                   o_cmd_err
);
   localparam logic [7:0] OP_RESET    = 8'd0;
   localparam logic [7:0] OP_EN_TX    = 8'd1;
   localparam logic [7:0] OP_EN_RX    = 8'd2;
   localparam logic [7:0] OP_PH_SEL   = 8'd3;
   localparam logic [7:0] OP_RUN_MEM  = 8'd4;
   localparam logic [7:0] OP_READ_MEM = 8'd5;
   localparam logic [7:0] OP_ADDR_MEM = 8'd6;
   localparam logic [7:0] OP_BER_SNAP = 8'd7;
   localparam logic [7:0] OP_BER_S_LO = 8'd8;
   localparam logic [7:0] OP_BER_S_HI = 8'd9;
   localparam logic [7:0] OP_BER_E_LO = 8'd10;
   localparam logic [7:0] OP_BER_E_HI = 8'd11;
   localparam logic [7:0] OP_MEM_FULL = 8'd12;
   localparam logic [7:0] OP_INFO     = 8'd13;

   localparam int          NB_RCNT   = $clog2(RST_LEN + 1);
   localparam int          NB_LCNT   = $clog2(MEM_RD_LAT + 1);
   localparam logic [4:0]  N_CH_W    = 5'(N_CH);
   localparam logic [31:0] INFO_WORD = {8'(N_CH), 8'(NB_ADDR_MEM), 8'(NB_PHASE), 8'(NB_CNT)};

   logic [31:0]        gpo_q;
   logic [31:0]        q_word;
   logic [31:0]        cmd;
   logic               en_hist;
   logic               q_valid;
   logic               rd_pend;
   logic [NB_LCNT-1:0] rd_cnt;
   logic [NB_RCNT-1:0] rst_cnt;
   logic               mf_q;
   logic               mf_d;
   logic [NB_CNT-1:0]  samp_sh [N_CH];
   logic [NB_CNT-1:0]  err_sh  [N_CH];
   logic               strobe;
   logic               exec;
   logic [7:0]         op;
   logic [3:0]         ch;
   logic               ch_ok;
   logic [63:0]        samp_sel;
   logic [63:0]        err_sel;
   logic               unused_cmd_bits;

   // A queued command (held back by a pending memory read) has priority over a fresh strobe.
   assign strobe          = gpo_q[23] & ~en_hist;
   assign exec            = ~rd_pend & (q_valid | strobe);
   assign cmd             = q_valid ? q_word : gpo_q;
   assign op              = cmd[31:24];
   assign ch              = cmd[3:0];
   assign ch_ok           = {1'b0, ch} < N_CH_W;
   assign unused_cmd_bits = ^cmd[23:0];

   always_comb begin
      samp_sel = '0;
      err_sel  = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (ch == 4'(c)) begin
            samp_sel = 64'(samp_sh[c]);
            err_sel  = 64'(err_sh[c]);
         end
      end
   end

   always_ff @(posedge clk) begin
      // Captured even in reset so the enable history sees a strobe held across release.
      gpo_q <= i_gpo;
      if (i_rst) begin
         o_gpi             <= '0;
         o_rst             <= 1'b0;
         o_enbTx           <= 1'b0;
         o_enbRx           <= 1'b0;
         o_phase_sel       <= '0;
         o_run_log         <= 1'b0;
         o_read_log        <= 1'b0;
         o_addr_log_to_mem <= '0;
         o_cmd_done        <= 1'b0;
         o_cmd_err         <= 1'b0;
         en_hist           <= 1'b1;
         q_valid           <= 1'b0;
         q_word            <= '0;
         rd_pend           <= 1'b0;
         rd_cnt            <= '0;
         rst_cnt           <= '0;
         mf_q              <= 1'b0;
         mf_d              <= 1'b0;
         for (int c = 0; c < N_CH; c++) begin
            samp_sh[c] <= '0;
            err_sh[c]  <= '0;
         end
      end else begin
         en_hist    <= gpo_q[23];
         mf_q       <= i_mem_full;
         mf_d       <= mf_q;
         o_cmd_done <= 1'b0;

         if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - NB_RCNT'(1);
            if (rst_cnt == NB_RCNT'(1)) o_rst <= 1'b0;
         end

         // Placed before command decode so a same-cycle RUN_MEM overrides the clear.
         if (mf_q & ~mf_d) o_run_log <= 1'b0;

         if (rd_pend) begin
            rd_cnt <= rd_cnt - NB_LCNT'(1);
            if (rd_cnt == NB_LCNT'(1)) begin
               rd_pend    <= 1'b0;
               o_gpi      <= i_data_log_from_mem;
               o_cmd_done <= 1'b1;
            end
         end

         // One-deep queue: a strobe during a pending read (or while the queue drains) is
         // held; a strobe arriving with the queue already full in the read window is lost.
         if (strobe && (rd_pend || q_valid)) begin
            if (!(rd_pend && q_valid)) begin
               q_word  <= gpo_q;
               q_valid <= 1'b1;
            end
         end else if (exec && q_valid) begin
            q_valid <= 1'b0;
         end

         if (exec) begin
            o_cmd_done <= 1'b1;
            case (op)
               OP_RESET: begin
                  if (cmd[0]) begin
                     o_rst   <= 1'b1;
                     rst_cnt <= NB_RCNT'(RST_LEN);
                  end
               end
               OP_EN_TX:    o_enbTx     <= cmd[0];
               OP_EN_RX:    o_enbRx     <= cmd[0];
               OP_PH_SEL:   o_phase_sel <= cmd[NB_PHASE-1:0];
               OP_RUN_MEM:  o_run_log   <= cmd[0];
               OP_READ_MEM: o_read_log  <= cmd[0];
               OP_ADDR_MEM: begin
                  o_addr_log_to_mem <= cmd[NB_ADDR_MEM-1:0];
                  rd_pend           <= 1'b1;
                  rd_cnt            <= NB_LCNT'(MEM_RD_LAT);
                  o_cmd_done        <= 1'b0;
               end
               OP_BER_SNAP: begin
                  for (int c = 0; c < N_CH; c++) begin
                     samp_sh[c] <= i_ber_samp[c*NB_CNT +: NB_CNT];
                     err_sh[c]  <= i_ber_error[c*NB_CNT +: NB_CNT];
                  end
               end
               OP_BER_S_LO, OP_BER_S_HI, OP_BER_E_LO, OP_BER_E_HI: begin
                  if (!ch_ok) begin
                     o_gpi     <= '0;
                     o_cmd_err <= 1'b1;
                  end else if (op == OP_BER_S_LO) begin
                     o_gpi <= samp_sel[31:0];
                  end else if (op == OP_BER_S_HI) begin
                     o_gpi <= samp_sel[63:32];
                  end else if (op == OP_BER_E_LO) begin
                     o_gpi <= err_sel[31:0];
                  end else begin
                     o_gpi <= err_sel[63:32];
                  end
               end
               OP_MEM_FULL: o_gpi <= {31'b0, i_mem_full};
               OP_INFO:     o_gpi <= INFO_WORD;
               default: begin
                  o_gpi     <= 32'hFFFF_FFFF;
                  o_cmd_err <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_register_file_mc.sv
`default_nettype none
// tb_register_file_mc: randomized bench comparing register_file_mc against a
// behavioural command model of the register file.
module tb_register_file_mc;
   localparam int N_CH   = 4;
   localparam int NB_CNT = 64;
   localparam int NB_ADR = 15;
   localparam int NB_PH  = 2;
   localparam int LAT    = 2;
   localparam int RSTL   = 4;

   logic                   clk = 1'b0;
   logic                   i_rst;
   logic [31:0]            i_gpo;
   logic [31:0]            i_data_log_from_mem;
   logic                   i_mem_full;
   logic [N_CH*NB_CNT-1:0] i_ber_samp;
   logic [N_CH*NB_CNT-1:0] i_ber_error;
   logic [31:0]            o_gpi;
   logic                   o_rst;
   logic                   o_enbTx;
   logic                   o_enbRx;
   logic [NB_PH-1:0]       o_phase_sel;
   logic                   o_run_log;
   logic                   o_read_log;
   logic [NB_ADR-1:0]      o_addr_log_to_mem;
   logic                   o_cmd_done;
   logic                   o_cmd_err;

   int checks = 0;
   int errors = 0;

   logic [63:0] live_s [N_CH];
   logic [63:0] live_e [N_CH];
   logic [63:0] snap_s [N_CH];
   logic [63:0] snap_e [N_CH];
   logic [31:0]       m_gpi;
   logic              m_tx, m_rx, m_run, m_rdl, m_err;
   logic [NB_PH-1:0]  m_ph;
   logic [NB_ADR-1:0] m_addr;

   register_file_mc #(
      .NB_ADDR_MEM(NB_ADR), .N_CH(N_CH), .NB_PHASE(NB_PH),
      .NB_CNT(NB_CNT), .MEM_RD_LAT(LAT), .RST_LEN(RSTL)
   ) dut (
      .clk(clk), .i_rst(i_rst), .i_gpo(i_gpo),
      .i_data_log_from_mem(i_data_log_from_mem), .i_mem_full(i_mem_full),
      .i_ber_samp(i_ber_samp), .i_ber_error(i_ber_error),
      .o_gpi(o_gpi), .o_rst(o_rst), .o_enbTx(o_enbTx), .o_enbRx(o_enbRx),
      .o_phase_sel(o_phase_sel), .o_run_log(o_run_log), .o_read_log(o_read_log),
      .o_addr_log_to_mem(o_addr_log_to_mem), .o_cmd_done(o_cmd_done), .o_cmd_err(o_cmd_err)
   );

   always #5 clk = ~clk;

   always_comb begin
      i_ber_samp  = '0;
      i_ber_error = '0;
      for (int c = 0; c < N_CH; c++) begin
         i_ber_samp[c*NB_CNT +: NB_CNT]  = live_s[c];
         i_ber_error[c*NB_CNT +: NB_CNT] = live_e[c];
      end
   end

   function automatic logic [55:0] outs();
      return {o_gpi, o_rst, o_enbTx, o_enbRx, o_phase_sel, o_run_log, o_read_log,
              o_addr_log_to_mem, o_cmd_err, o_cmd_done};
   endfunction

   function automatic logic [55:0] expect_after_cmd();
      return {m_gpi, 1'b0, m_tx, m_rx, m_ph, m_run, m_rdl, m_addr, m_err, 1'b1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_live();
      for (int c = 0; c < N_CH; c++) begin
         live_s[c] = {$urandom, $urandom};
         live_e[c] = {$urandom, $urandom};
      end
   endtask

   task automatic model_cmd(input logic [7:0] op, input logic [22:0] d);
      int          idx;
      logic [63:0] word;
      idx = int'(d[3:0]);
      case (op)
         8'd1: m_tx = d[0];
         8'd2: m_rx = d[0];
         8'd3: m_ph = d[NB_PH-1:0];
         8'd4: m_run = d[0];
         8'd5: m_rdl = d[0];
         8'd6: m_addr = d[NB_ADR-1:0];
         8'd7: begin
            for (int c = 0; c < N_CH; c++) begin
               snap_s[c] = live_s[c];
               snap_e[c] = live_e[c];
            end
         end
         8'd8, 8'd9, 8'd10, 8'd11: begin
            if (idx >= N_CH) begin
               m_gpi = 32'h0;
               m_err = 1'b1;
            end else begin
               word  = (op < 8'd10) ? snap_s[idx] : snap_e[idx];
               m_gpi = op[0] ? word[63:32] : word[31:0];
            end
         end
         8'd12: m_gpi = {31'b0, i_mem_full};
         8'd13: m_gpi = 32'h040F_0240;
         default: begin
            if (op >= 8'd14) begin
               m_gpi = 32'hFFFF_FFFF;
               m_err = 1'b1;
            end
         end
      endcase
   endtask

   // One-cycle strobe; returns one step after the execute edge.
   task automatic send(input logic [7:0] op, input logic [22:0] d);
      model_cmd(op, d);
      i_gpo = {op, 1'b1, d};
      tick();
      i_gpo[23] = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic seen_done;
      i_rst = 1'b1;
      i_gpo = {8'd1, 1'b1, 23'd1};
      repeat (3) tick();
      checks++;
      if (outs() !== 56'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h exp %h", outs(), 56'h0);
      end
      i_rst = 1'b0;
      seen_done = 1'b0;
      repeat (4) begin
         tick();
         if (o_cmd_done) seen_done = 1'b1;
      end
      checks++;
      if ({o_enbTx, seen_done} !== 2'b00) begin
         errors++;
         $display("FAIL held_strobe_at_release: got tx/done %b exp 00", {o_enbTx, seen_done});
      end
      i_gpo[23] = 1'b0;
      tick();
      i_gpo[23] = 1'b1;
      tick();
      checks++;
      if (o_enbTx !== 1'b0) begin
         errors++;
         $display("FAIL en_tx_early: got %b exp 0", o_enbTx);
      end
      tick();
      checks++;
      if ({o_enbTx, o_cmd_done} !== 2'b11) begin
         errors++;
         $display("FAIL en_tx_second_edge: got tx/done %b exp 11", {o_enbTx, o_cmd_done});
      end
      i_gpo[0] = 1'b0;
      tick();
      tick();
      checks++;
      if ({o_enbTx, o_cmd_done} !== 2'b10) begin
         errors++;
         $display("FAIL level_strobe_once: got tx/done %b exp 10", {o_enbTx, o_cmd_done});
      end
      i_gpo[23] = 1'b0;
      tick();
      m_tx = 1'b1;
   endtask

   task automatic test_back_to_back();
      send(8'd2, 23'd1);
      checks++;
      if (outs() !== expect_after_cmd()) begin
         errors++;
         $display("FAIL b2b_en_rx: got %h exp %h", outs(), expect_after_cmd());
      end
      send(8'd1, 23'd0);
      checks++;
      if (outs() !== expect_after_cmd()) begin
         errors++;
         $display("FAIL b2b_en_tx: got %h exp %h", outs(), expect_after_cmd());
      end
      send(8'd2, 23'd0);
      checks++;
      if (outs() !== expect_after_cmd()) begin
         errors++;
         $display("FAIL b2b_en_rx_off: got %h exp %h", outs(), expect_after_cmd());
      end
   endtask

   task automatic test_sw_reset();
      int n;
      send(8'd0, 23'd0);
      n = 0;
      repeat (8) begin
         if (o_rst) n++;
         tick();
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL sw_reset_noop: got %0d high cycles exp 0", n);
      end
      send(8'd0, 23'd1);
      n = 0;
      repeat (10) begin
         if (o_rst) n++;
         tick();
      end
      checks++;
      if (n != RSTL) begin
         errors++;
         $display("FAIL sw_reset_len: got %0d high cycles exp %0d", n, RSTL);
      end
      send(8'd0, 23'd1);
      n = 0;
      if (o_rst) n++;
      i_gpo = {8'd0, 1'b1, 23'd1};
      tick();
      if (o_rst) n++;
      i_gpo[23] = 1'b0;
      tick();
      repeat (10) begin
         if (o_rst) n++;
         tick();
      end
      checks++;
      if (n != 2 + RSTL) begin
         errors++;
         $display("FAIL sw_reset_restart: got %0d high cycles exp %0d", n, 2 + RSTL);
      end
   endtask

   task automatic test_ber();
      randomize_live();
      live_s[2] = 64'h0AFB_2344_53BC_DE21;
      send(8'd7, 23'd0);
      checks++;
      if (outs() !== expect_after_cmd()) begin
         errors++;
         $display("FAIL ber_snap_gpi_hold: got %h exp %h", outs(), expect_after_cmd());
      end
      randomize_live();
      live_s[2] = 64'h0;
      send(8'd8, 23'd2);
      checks++;
      if (o_gpi !== 32'h53BC_DE21) begin
         errors++;
         $display("FAIL ber_s_lo_ch2: got %h exp 53bcde21", o_gpi);
      end
      send(8'd9, 23'd2);
      checks++;
      if (o_gpi !== 32'h0AFB_2344) begin
         errors++;
         $display("FAIL ber_s_hi_ch2: got %h exp 0afb2344", o_gpi);
      end
      send(8'd10, 23'd1);
      checks++;
      if (outs() !== expect_after_cmd()) begin
         errors++;
         $display("FAIL ber_e_lo_ch1: got %h exp %h", outs(), expect_after_cmd());
      end
      send(8'd11, 23'd3);
      checks++;
      if (outs() !== expect_after_cmd()) begin
         errors++;
         $display("FAIL ber_e_hi_ch3: got %h exp %h", outs(), expect_after_cmd());
      end
      send(8'd8, 23'd5);
      checks++;
      if ({o_gpi, o_cmd_err} !== {32'h0, 1'b1}) begin
         errors++;
         $display("FAIL ber_bad_channel: got gpi %h err %b exp gpi 0 err 1", o_gpi, o_cmd_err);
      end
   endtask

   task automatic test_mem_full();
      send(8'd4, 23'd1);
      checks++;
      if (o_run_log !== 1'b1) begin
         errors++;
         $display("FAIL run_mem_on: got %b exp 1", o_run_log);
      end
      i_mem_full = 1'b1;
      tick();
      tick();
      m_run = 1'b0;
      checks++;
      if (o_run_log !== 1'b0) begin
         errors++;
         $display("FAIL mem_full_stops_run: got %b exp 0", o_run_log);
      end
      send(8'd12, 23'd0);
      checks++;
      if (o_gpi !== 32'h0000_0001) begin
         errors++;
         $display("FAIL is_mem_full: got %h exp 00000001", o_gpi);
      end
      i_mem_full = 1'b0;
      tick();
      tick();
      model_cmd(8'd4, 23'd1);
      i_gpo      = {8'd4, 1'b1, 23'd1};
      i_mem_full = 1'b1;
      tick();
      i_gpo[23] = 1'b0;
      tick();
      checks++;
      if (outs() !== expect_after_cmd()) begin
         errors++;
         $display("FAIL run_cmd_beats_full_edge: got %h exp %h", outs(), expect_after_cmd());
      end
   endtask

   task automatic test_addr_mem();
      logic [31:0] rnd;
      i_data_log_from_mem = 32'hDEAD_BEEF;
      model_cmd(8'd6, 23'h35EB1C);
      i_gpo = {8'd6, 1'b1, 23'h35EB1C};
      tick();
      i_gpo[23] = 1'b0;
      tick();
      checks++;
      if ({o_addr_log_to_mem, o_cmd_done} !== {15'h6B1C, 1'b0}) begin
         errors++;
         $display("FAIL addr_mem_addr: got addr %h done %b exp 6b1c 0", o_addr_log_to_mem, o_cmd_done);
      end
      tick();
      i_data_log_from_mem = 32'h0000_AF0F;
      tick();
      i_data_log_from_mem = 32'hDEAD_BEEF;
      m_gpi = 32'h0000_AF0F;
      checks++;
      if ({o_gpi, o_cmd_done} !== {32'h0000_AF0F, 1'b1}) begin
         errors++;
         $display("FAIL addr_mem_data: got gpi %h done %b exp 0000af0f 1", o_gpi, o_cmd_done);
      end
      rnd = $urandom;
      model_cmd(8'd6, 23'h000123);
      i_gpo = {8'd6, 1'b1, 23'h000123};
      tick();
      i_gpo[23] = 1'b0;
      tick();
      i_gpo = {8'd2, 1'b1, 23'd1};
      tick();
      i_gpo[23] = 1'b0;
      i_data_log_from_mem = rnd;
      tick();
      i_data_log_from_mem = 32'hDEAD_BEEF;
      m_gpi = rnd;
      checks++;
      if ({o_gpi, o_enbRx, o_cmd_done} !== {rnd, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL queued_read_first: got gpi %h rx %b done %b exp %h 0 1", o_gpi, o_enbRx, o_cmd_done, rnd);
      end
      tick();
      m_rx = 1'b1;
      checks++;
      if (outs() !== expect_after_cmd()) begin
         errors++;
         $display("FAIL queued_cmd_runs: got %h exp %h", outs(), expect_after_cmd());
      end
   endtask

   task automatic test_misc();
      send(8'd200, 23'($urandom));
      checks++;
      if (outs() !== expect_after_cmd() || o_gpi !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL illegal_opcode: got %h exp %h", outs(), expect_after_cmd());
      end
      send(8'd3, 23'd3);
      checks++;
      if (o_phase_sel !== 2'd3) begin
         errors++;
         $display("FAIL ph_sel: got %0d exp 3", o_phase_sel);
      end
      send(8'd13, 23'd0);
      checks++;
      if (o_gpi !== 32'h040F_0240) begin
         errors++;
         $display("FAIL info: got %h exp 040f0240", o_gpi);
      end
      send(8'd5, 23'd1);
      checks++;
      if (outs() !== expect_after_cmd()) begin
         errors++;
         $display("FAIL read_mem: got %h exp %h", outs(), expect_after_cmd());
      end
   endtask

   task automatic test_random();
      logic [7:0]  ops [13];
      logic [7:0]  op;
      logic [22:0] d;
      ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
      for (int i = 0; i < 60; i++) begin
         op = ops[$urandom_range(0, 12)];
         if (op == 8'd14) op = 8'($urandom_range(14, 255));
         if (op == 8'd7) randomize_live();
         d      = 23'($urandom);
         d[3:0] = 4'($urandom_range(0, 5));
         send(op, d);
         checks++;
         if (outs() !== expect_after_cmd()) begin
            errors++;
            $display("FAIL random_cmd op %0d d %h: got %h exp %h", op, d, outs(), expect_after_cmd());
         end
         if (i % 7 == 3) randomize_live();
      end
   endtask

   task automatic test_abort();
      logic seen_done;
      send(8'd0, 23'd1);
      i_rst = 1'b1;
      tick();
      checks++;
      if (outs() !== 56'h0) begin
         errors++;
         $display("FAIL abort_reset_pulse: got %h exp 0", outs());
      end
      i_rst = 1'b0;
      tick();
      send(8'd6, 23'd5);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      i_data_log_from_mem = 32'h1234_5678;
      seen_done = 1'b0;
      repeat (5) begin
         tick();
         if (o_cmd_done) seen_done = 1'b1;
      end
      checks++;
      if ({o_gpi, seen_done} !== {32'h0, 1'b0}) begin
         errors++;
         $display("FAIL abort_pending_read: got gpi %h done %b exp 0 0", o_gpi, seen_done);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      i_gpo = '0;
      i_data_log_from_mem = '0;
      i_mem_full = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         live_s[c] = '0;
         live_e[c] = '0;
         snap_s[c] = '0;
         snap_e[c] = '0;
      end
      m_gpi = '0; m_tx = 0; m_rx = 0; m_run = 0; m_rdl = 0; m_err = 0; m_ph = '0; m_addr = '0;
      test_reset();
      test_back_to_back();
      test_sw_reset();
      test_ber();
      test_mem_full();
      test_addr_mem();
      test_misc();
      test_random();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/register_file_mc.md
Name: register_file_mc

Overview:
- Parametrised, multi-channel successor to the system register file.
- Decodes microprocessor GPO command words, which carry an opcode, an enable strobe and a data field.
- Drives Tx/Rx control, phase select, software reset and the data-log memory.
- Returns BER counters, memory data and status on GPI; 64-bit counters of N_CH channels are snapshotted atomically so that LO/HI word reads are coherent.

Parameters:
- NB_ADDR_MEM, 15, log-memory address width (≤23).
- N_CH, 4, number of BER channels (1..16).
- NB_PHASE, 2, phase-select width (≤23).
- NB_CNT, 64, BER counter width (33..64); HI word is zero-extended.
- MEM_RD_LAT, 1, cycles from o_addr_log_to_mem update to the memory data being valid (1..4).
- RST_LEN, 4, software-reset pulse length in clocks (≥1).

Ports:
- clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_gpo  in  32  command word: [31:24] opcode, [23] enable strobe, [22:0] data.
- i_data_log_from_mem  in  32  log-memory read data.
- i_mem_full  in  1  log memory full.
- i_ber_samp  in  N_CH*NB_CNT  sample counters, channel c at [c*NB_CNT +: NB_CNT].
- i_ber_error  in  N_CH*NB_CNT  error counters, same packing.
- o_gpi  out  32  read-back word.
- o_rst  out  1  software reset pulse.
- o_enbTx  out  1  Tx enable.
- o_enbRx  out  1  Rx enable.
- o_phase_sel  out  NB_PHASE  filter phase.
- o_run_log  out  1  logging active.
- o_read_log  out  1  memory read mode.
- o_addr_log_to_mem  out  NB_ADDR_MEM  memory read address.
- o_cmd_done  out  1  one-cycle pulse per executed command.
- o_cmd_err  out  1  sticky error for an illegal opcode or channel.

Behaviour:
- Reset (i_rst=1 at an edge):
  - All outputs become 0.
  - Snapshot registers and the reset counter become 0.
  - The stored enable history becomes 1, so a strobe already high at reset release is not a command.
- Strobe detection and timing:
  - i_gpo is registered (gpo_q).
  - A command executes on a rising edge of gpo_q[23] versus its previous value.
  - If i_gpo is set before edge E0, it is captured at E0 and its outputs update at E1; o_cmd_done is high for the cycle after E1.
  - A level-high strobe executes once. Data/opcode changes while the strobe stays high are ignored.
  - Back-to-back strobes are legal at 1 command per 2 cycles.
- Let D = gpo_q[22:0] and ch = D[3:0]. Opcodes:
  - 0 RESET: if D[0]=1, o_rst=1 for exactly RST_LEN cycles. Re-issuing during a pulse restarts the count. D[0]=0 is a no-op.
  - 1 EN_TX: o_enbTx<=D[0].
  - 2 EN_RX: o_enbRx<=D[0].
  - 3 PH_SEL: o_phase_sel<=D[NB_PHASE-1:0].
  - 4 RUN_MEM: o_run_log<=D[0].
    - A rising edge of i_mem_full (registered) clears o_run_log.
    - If the command and that rising edge occur in the same cycle, the command wins.
  - 5 READ_MEM: o_read_log<=D[0].
  - 6 ADDR_MEM: o_addr_log_to_mem<=D[NB_ADDR_MEM-1:0] at E1. o_gpi<=i_data_log_from_mem, sampled MEM_RD_LAT cycles after E1. o_cmd_done is pulsed at that capture, not at E1.
  - 7 BER_SNAP: all N_CH sample and error counters are copied in one cycle into shadow registers; o_gpi is unchanged.
  - 8 BER_S_LO / 9 BER_S_HI: o_gpi<=shadow sample[ch] bits [31:0] / [NB_CNT-1:32] zero-extended.
  - 10 BER_E_LO / 11 BER_E_HI: same for the error counters.
  - 12 IS_MEM_FULL: o_gpi<={31'b0, i_mem_full}.
  - 13 INFO: o_gpi<={8'(N_CH), 8'(NB_ADDR_MEM), 8'(NB_PHASE), 8'(NB_CNT)}.
- Opcodes 8–11 with ch≥N_CH: o_gpi<=0 and o_cmd_err<=1.
- Opcodes ≥14: o_gpi<=32'hFFFF_FFFF and o_cmd_err<=1; no other output changes.
- o_cmd_err clears only on i_rst.
- o_gpi holds its value until the next read-type command.
- Live counters never reach o_gpi without a BER_SNAP.
- A new strobe during the ADDR_MEM latency window: the pending capture completes first. The new command is executed afterwards; only that one is queued, and further strobes are dropped.
- i_rst asserted mid-operation (reset pulse, pending memory read) aborts everything in the same edge.

Test Plan:
- Reset release with i_gpo={8'd1,1'b1,23'd1} held → o_enbTx stays 0 and no o_cmd_done; drop then raise bit 23 → o_enbTx=1 two edges after the raise, o_cmd_done=1 for one cycle.
- RESET D=1 with RST_LEN=4 → o_rst high exactly 4 cycles. Re-issue on pulse cycle 2 → total high 2+4=6 cycles.
- Channel 2 counter = 64'h0AFB_2344_53BC_DE21, BER_SNAP, then change the counter to 0 → BER_S_LO ch=2 gives 53BCDE21 and BER_S_HI ch=2 gives 0AFB2344. ch=5 with N_CH=4 → o_gpi=0 and o_cmd_err=1.
- RUN_MEM D=1 → o_run_log=1. i_mem_full 0→1 → o_run_log=0 within 2 cycles; IS_MEM_FULL reads 00000001.
- ADDR_MEM D=23'h35EB1C with NB_ADDR_MEM=15 → o_addr_log_to_mem=15'h6B1C. Memory model returns 32'h0000AF0F after MEM_RD_LAT=2 → o_gpi=0000AF0F.
- Opcode 8'd200 → o_gpi=FFFFFFFF, o_cmd_err=1; PH_SEL D=3 → o_phase_sel=3; INFO → 040F0240.
